acc_result_buffer: RTL



---
 rtl/acc_result_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/acc_result_buffer.sv
// ---------------------------------------------------------------------------
// acc_result_buffer
//
// Purpose:
//   This block sits after the difference accumulator. It catches every
//   one-cycle result pulse in a small FIFO, so a completed accumulation is
//   never lost while the consumer is stalled. Results leave through a
//   valid/ready handshake. The block also keeps a sticky flag for dropped
//   results and a saturating count of accepted results.
//
// Ports:
//   clock         system clock; all state changes on the rising edge
//   rst           synchronous, active-high reset; overrides every other input
//   in_valid      one-cycle pulse from the accumulator (result complete)
//   in_data       accumulated result, sampled when in_valid=1
//   out_valid     a head entry is available
//   out_data      value of the head entry; 0 when the FIFO is empty
//   out_ready     consumer takes the head this cycle when out_valid=1
//   count         current occupancy, 0..DEPTH
//   full          occupancy equals DEPTH
//   overflow      sticky; set when a result was dropped
//   overflow_clr  clears overflow (a drop in the same cycle wins)
//   accepted      total results written, saturating at all-ones
// ---------------------------------------------------------------------------
module acc_result_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [CNT_W-1:0]         accepted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_accepted;

    logic w_outValid;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Handshake decode. Empty and full come from the occupancy count, not
    // from comparing pointers, so both pointers can simply wrap. A push
    // into a full FIFO still succeeds when the head leaves on the same edge,
    // because the freed slot is the one the write pointer points at.
    always_comb begin
        w_outValid = (r_count != '0);
        w_full     = (r_count == FULL_CNT);
        w_pop      = w_outValid & out_ready;
        w_push     = in_valid & (~w_full | w_pop);
        w_drop     = in_valid & w_full & ~w_pop;
    end

    // Storage. It has no reset because its contents are don't-care until
    // the count says a slot is valid. Writes are blocked during reset so an
    // in_valid in the reset cycle leaves no trace.
    always_ff @(posedge clock) begin
        if (!rst && w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    // Control state: pointers, occupancy, sticky overflow and the accepted
    // counter. A drop and overflow_clr in the same cycle leave the flag set,
    // so a loss is never hidden by a clear that races with it.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_accepted <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
                if (r_accepted != '1) begin
                    r_accepted <= r_accepted + CNT_W'(1);
                end
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Outputs come straight from registered state. There is no bypass path,
    // so a result shows up on out_valid no earlier than one cycle after its
    // in_valid pulse. Keeping the head stable while stalled needs no extra
    // logic: rd_ptr only moves on a pop.
    always_comb begin
        out_valid = w_outValid;
        out_data  = w_outValid ? r_mem[r_rdPtr] : '0;
        count     = r_count;
        full      = w_full;
        overflow  = r_overflow;
        accepted  = r_accepted;
    end

endmodule
